// File: rtl/picodevice_axil_pkg.sv
// Shared definitions for the PicoDevice AXI4-lite memory slave.
//   AXIL_ADDR_W / AXIL_DATA_W / AXIL_STRB_W : bus field widths.
//   axil_in_range()                         : region decode without 32-bit wrap.
package picodevice_axil_pkg;

    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_STRB_W = 4;

    // True iff base <= addr < base + len. Widened to 33 bits so a region that
    // ends exactly at 2^32 does not wrap to zero.
    function automatic logic axil_in_range(input logic [AXIL_ADDR_W-1:0] addr,
                                           input logic [AXIL_ADDR_W-1:0] base,
                                           input logic [AXIL_ADDR_W-1:0] len);
        logic [AXIL_ADDR_W:0] a;
        logic [AXIL_ADDR_W:0] lo;
        logic [AXIL_ADDR_W:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = {1'b0, base} + {1'b0, len};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/picodevice_bram_be.sv
// Single-clock word RAM with one byte-enabled write port and one registered
// read port. A read and write to the same word on the same edge returns the
// old contents. Contents are not reset.
//   clk_i   : clock
//   we_i    : write enable; wstrb_i selects the bytes written at waddr_i
//   re_i    : read enable; rdata_o updates from raddr_i on the next edge and
//             otherwise holds its value
module picodevice_bram_be
    import picodevice_axil_pkg::*;
#(
    parameter int unsigned Depth = 64,
    parameter int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [AddrW-1:0]       waddr_i,
    input  logic [AXIL_DATA_W-1:0] wdata_i,
    input  logic [AXIL_STRB_W-1:0] wstrb_i,
    input  logic                   re_i,
    input  logic [AddrW-1:0]       raddr_i,
    output logic [AXIL_DATA_W-1:0] rdata_o
);

    logic [AXIL_DATA_W-1:0] mem_q [Depth];
    logic [AXIL_DATA_W-1:0] rdata_q;

    // Both updates are non-blocking, so a same-edge read samples pre-write data.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(AXIL_STRB_W); i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/picodevice_axil_ram.sv
// AXI4-lite slave word memory with byte enables at [MEM_BASE, MEM_BASE+MEM_LEN).
// Independent write and read channels, one outstanding transaction on each.
//   clk, resetn          : clock, asynchronous active-low reset
//   s_axi_aw* / s_axi_w* : write address / data; AW and W accepted in any order
//   s_axi_b*             : write response (no bresp; always OKAY)
//   s_axi_ar* / s_axi_r* : read address / data, one-cycle latency
//   oor_err              : one-cycle pulse when an out-of-range access commits
module picodevice_axil_ram
    import picodevice_axil_pkg::*;
#(
    parameter logic [AXIL_ADDR_W-1:0] MEM_BASE = 32'h0001_0000,
    parameter logic [AXIL_ADDR_W-1:0] MEM_LEN  = 32'h0000_0100
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [AXIL_ADDR_W-1:0] s_axi_awaddr,
    input  logic [2:0]             s_axi_awprot,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    input  logic [AXIL_DATA_W-1:0] s_axi_wdata,
    input  logic [AXIL_STRB_W-1:0] s_axi_wstrb,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    input  logic [AXIL_ADDR_W-1:0] s_axi_araddr,
    input  logic [2:0]             s_axi_arprot,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [AXIL_DATA_W-1:0] s_axi_rdata,
    output logic                   oor_err
);

    localparam int unsigned Depth = int'(MEM_LEN >> 2);
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    // Write channel holding registers
    logic                   aw_held_q, aw_held_d;
    logic [AXIL_ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic                   w_held_q,  w_held_d;
    logic [AXIL_DATA_W-1:0] wdata_q,   wdata_d;
    logic [AXIL_STRB_W-1:0] wstrb_q,   wstrb_d;
    logic                   bvalid_q,  bvalid_d;

    // Read channel state; rd_ok_q selects RAM data vs. zero on the R channel
    logic                   rvalid_q,  rvalid_d;
    logic                   rd_ok_q,   rd_ok_d;
    logic                   oor_err_q, oor_err_d;

    logic                   aw_hs;
    logic                   w_hs;
    logic                   ar_hs;
    logic                   commit;
    logic                   wr_in_range;
    logic                   rd_in_range;
    logic [AXIL_ADDR_W-1:0] wr_off;
    logic [AXIL_ADDR_W-1:0] rd_off;
    logic [AddrW-1:0]       wr_idx;
    logic [AddrW-1:0]       rd_idx;
    logic [AXIL_DATA_W-1:0] ram_rdata;
    logic                   unused_sig;

    assign aw_hs  = s_axi_awvalid && !aw_held_q;
    assign w_hs   = s_axi_wvalid && !w_held_q;
    assign ar_hs  = s_axi_arvalid && !rvalid_q;
    // A pending B blocks the next commit so B beats never merge.
    assign commit = aw_held_q && w_held_q && !bvalid_q;

    assign wr_in_range = axil_in_range(awaddr_q, MEM_BASE, MEM_LEN);
    assign rd_in_range = axil_in_range(s_axi_araddr, MEM_BASE, MEM_LEN);

    // Word index from the offset; only meaningful when in range.
    assign wr_off = awaddr_q - MEM_BASE;
    assign rd_off = s_axi_araddr - MEM_BASE;
    assign wr_idx = wr_off[AddrW+1:2];
    assign rd_idx = rd_off[AddrW+1:2];

    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rd_ok_d   = rd_ok_q;

        // Handshake and commit are mutually exclusive: ready is low while held.
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end else if (commit) begin
            aw_held_d = 1'b0;
        end

        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end else if (commit) begin
            w_held_d = 1'b0;
        end

        if (commit) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rd_ok_d  = rd_in_range;
        end else if (rvalid_q && s_axi_rready) begin
            rvalid_d = 1'b0;
        end

        // Simultaneous read and write misses collapse into a single pulse.
        oor_err_d = (commit && !wr_in_range) || (ar_hs && !rd_in_range);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rd_ok_q   <= 1'b0;
            oor_err_q <= 1'b0;
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rd_ok_q   <= rd_ok_d;
            oor_err_q <= oor_err_d;
        end
    end

    picodevice_bram_be #(
        .Depth (Depth),
        .AddrW (AddrW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (commit && wr_in_range),
        .waddr_i (wr_idx),
        .wdata_i (wdata_q),
        .wstrb_i (wstrb_q),
        .re_i    (ar_hs && rd_in_range),
        .raddr_i (rd_idx),
        .rdata_o (ram_rdata)
    );

    assign s_axi_awready = !aw_held_q;
    assign s_axi_wready  = !w_held_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_arready = !rvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rd_ok_q ? ram_rdata : '0;
    assign oor_err       = oor_err_q;

    assign unused_sig = ^{s_axi_awprot, s_axi_arprot, wr_off, rd_off};

endmodule

// File: tb/tb_picodevice_axil_ram.sv
// Directed bench for picodevice_axil_ram. Inputs change 1ns after the rising
// edge and outputs are sampled at the same point.
module tb_picodevice_axil_ram;

    logic        clk;
    logic        resetn;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic        oor_err;

    int checks = 0;
    int errors = 0;
    int b_cnt  = 0;
    int oor_cnt = 0;

    picodevice_axil_ram #(
        .MEM_BASE (32'h0001_0000),
        .MEM_LEN  (32'h0000_0100)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_awaddr  (awaddr),
        .s_axi_awprot  (awprot),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_araddr  (araddr),
        .s_axi_arprot  (arprot),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .s_axi_rdata   (rdata),
        .oor_err       (oor_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count B beats and error pulses as seen at each edge.
    always @(posedge clk) begin
        if (bvalid && bready) b_cnt <= b_cnt + 1;
        if (oor_err) oor_cnt <= oor_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue AW and W together, then wait for and accept B. ok=1 if B was seen.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic ok);
        logic aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            n++;
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
        end
        n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        ok = bvalid;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    // Issue AR and accept R. ok=1 if R was seen.
    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic ok);
        logic done, hs;
        int n;
        done = 1'b0; n = 0;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        while (!done && n < 20) begin
            hs = arvalid && arready;
            tick();
            n++;
            if (hs) begin done = 1'b1; arvalid = 1'b0; end
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin tick(); n++; end
        ok = rvalid;
        d = rdata;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, oor_err} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 111000",
                     {awready, wready, arready, bvalid, rvalid, oor_err});
        end
        checks++;
        if (rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got %h want 00000000", rdata);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL post_reset got %b want 11100",
                     {awready, wready, arready, bvalid, rvalid});
        end
    endtask

    task automatic test_same_cycle_write();
        awaddr = 32'h0001_0004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL b_early got %b want 0", bvalid);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++; $display("FAIL b_latency got %b want 1", bvalid);
        end
        tick();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL b_one_beat got %b want 0", bvalid);
        end
        araddr = 32'h0001_0004; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL r_latency got rvalid=%b rdata=%h want 1 deadbeef", rvalid, rdata);
        end
        rready = 1'b1;
        tick();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++; $display("FAIL r_clear got %b want 0", rvalid);
        end
    endtask

    task automatic test_w_before_aw();
        logic ok;
        logic [31:0] d;
        int oor0;
        do_write(32'h0001_0008, 32'h1122_3344, 4'hF, ok);
        oor0 = oor_cnt;
        wdata = 32'h0000_5500; wstrb = 4'b0010; wvalid = 1'b1; bready = 1'b1;
        tick();
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL w_held got wready=%b awready=%b want 0 1", wready, awready);
        end
        tick(); tick();
        awaddr = 32'h0001_0008; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL wfirst_b_early got %b want 0", bvalid);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++; $display("FAIL wfirst_b got %b want 1", bvalid);
        end
        tick();
        do_read(32'h0001_0008, d, ok);
        checks++;
        if (ok !== 1'b1 || d !== 32'h1122_5544) begin
            errors++; $display("FAIL strobe_merge got %h want 11225544", d);
        end
        checks++;
        if (oor_cnt !== oor0) begin
            errors++; $display("FAIL no_oor got %0d pulses want 0", oor_cnt - oor0);
        end
    endtask

    task automatic test_b_backpressure();
        logic ok;
        logic [31:0] d;
        int b0;
        b0 = b_cnt;
        bready = 1'b0;
        awaddr = 32'h0001_000C; wdata = 32'hA1A1_A1A1; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++; $display("FAIL bp_first_b got %b want 1", bvalid);
        end
        awaddr = 32'h0001_0010; wdata = 32'hB2B2_B2B2; awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (4) tick();
        checks++;
        if ({bvalid, awready, wready} !== 3'b100 || b_cnt !== b0) begin
            errors++;
            $display("FAIL bp_hold got bvalid/awready/wready=%b beats=%0d want 100 0",
                     {bvalid, awready, wready}, b_cnt - b0);
        end
        bready = 1'b1;
        tick();
        checks++;
        if (bvalid !== 1'b0) begin
            errors++; $display("FAIL bp_gap got %b want 0", bvalid);
        end
        tick();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++; $display("FAIL bp_second_b got %b want 1", bvalid);
        end
        tick(); tick();
        checks++;
        if (b_cnt - b0 !== 2) begin
            errors++; $display("FAIL bp_beats got %0d want 2", b_cnt - b0);
        end
        do_read(32'h0001_000C, d, ok);
        checks++;
        if (d !== 32'hA1A1_A1A1) begin
            errors++; $display("FAIL bp_data0 got %h want a1a1a1a1", d);
        end
        do_read(32'h0001_0010, d, ok);
        checks++;
        if (d !== 32'hB2B2_B2B2) begin
            errors++; $display("FAIL bp_data1 got %h want b2b2b2b2", d);
        end
    endtask

    task automatic test_out_of_range();
        logic ok;
        logic [31:0] d;
        do_write(32'h0001_00FC, 32'h0BAD_F00D, 4'hF, ok);
        araddr = 32'h0001_0100; arvalid = 1'b1; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        checks++;
        if ({rvalid, oor_err} !== 2'b11 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL oor_read got rvalid=%b oor=%b rdata=%h want 1 1 00000000",
                     rvalid, oor_err, rdata);
        end
        rready = 1'b1;
        tick();
        checks++;
        if (oor_err !== 1'b0) begin
            errors++; $display("FAIL oor_pulse_width got %b want 0", oor_err);
        end
        awaddr = 32'h0000_FFFC; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        checks++;
        if ({bvalid, oor_err} !== 2'b11) begin
            errors++;
            $display("FAIL oor_write got bvalid=%b oor=%b want 1 1", bvalid, oor_err);
        end
        tick();
        do_read(32'h0001_00FC, d, ok);
        checks++;
        if (d !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL oor_no_write got %h want 0badf00d", d);
        end
    endtask

    task automatic test_r_backpressure();
        logic ok;
        logic [31:0] d;
        araddr = 32'h0001_0008; arvalid = 1'b1; rready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rvalid !== 1'b1 || arready !== 1'b0 || rdata !== 32'h1122_5544) begin
                errors++;
                $display("FAIL r_hold[%0d] got rvalid=%b arready=%b rdata=%h want 1 0 11225544",
                         i, rvalid, arready, rdata);
            end
            tick();
        end
        arvalid = 1'b0; rready = 1'b1;
        tick();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++; $display("FAIL r_release got %b want 0", rvalid);
        end
        // Same-edge read and write commit to idx 2.
        do_write(32'h0001_0008, 32'hAAAA_AAAA, 4'hF, ok);
        awaddr = 32'h0001_0008; wdata = 32'h5555_5555; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h0001_0008; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        checks++;
        if ({rvalid, bvalid} !== 2'b11 || rdata !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL rbw got rvalid/bvalid=%b rdata=%h want 11 aaaaaaaa",
                     {rvalid, bvalid}, rdata);
        end
        rready = 1'b1; bready = 1'b1;
        tick();
        do_read(32'h0001_0008, d, ok);
        checks++;
        if (d !== 32'h5555_5555) begin
            errors++; $display("FAIL rbw_after got %h want 55555555", d);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        int b0;
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h0001_0014; wdata = 32'h1234_5678; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        awaddr = 32'h0001_0018; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        araddr = 32'h0001_0014; arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        checks++;
        if ({bvalid, rvalid, awready} !== 3'b110) begin
            errors++;
            $display("FAIL pre_reset got bvalid/rvalid/awready=%b want 110",
                     {bvalid, rvalid, awready});
        end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({bvalid, rvalid} !== 2'b00) begin
            errors++; $display("FAIL async_reset got bvalid/rvalid=%b want 00", {bvalid, rvalid});
        end
        tick(); tick();
        resetn = 1'b1;
        bready = 1'b1; rready = 1'b1;
        tick();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL ready_after_reset got %b want 111", {awready, wready, arready});
        end
        b0 = b_cnt;
        // A stale held AW would pair with this W and produce a B.
        wdata = 32'h0F0F_0F0F; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        repeat (4) tick();
        checks++;
        if (b_cnt !== b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL stale_b got beats=%0d rvalid=%b want 0 0", b_cnt - b0, rvalid);
        end
        awaddr = 32'h0001_0018; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        tick();
        checks++;
        if (bvalid !== 1'b1) begin
            errors++; $display("FAIL resume_write got %b want 1", bvalid);
        end
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        awvalid = 1'b0; awaddr = '0; awprot = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0;
        bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arprot = '0;
        rready = 1'b0;
        #1;
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_b_backpressure();
        test_out_of_range();
        test_r_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
